// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch with a one-entry skid buffer feeding a
// registered decode (ID) stage. A taken redirect flushes the ID stage; a
// request still outstanding at redirect time is drained and its data dropped.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  SVPC_OP  = 4'b1111
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [3:0]  o_opcode,
  output logic [5:0]  o_rd,
  output logic [5:0]  o_rs,
  output logic [5:0]  o_rt,
  output logic [11:0] o_const,
  output logic        o_Gen
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_target;
  logic        r_skid_valid;
  logic [21:0] r_skid_word;
  logic [31:0] r_skid_pc;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [3:0]  r_opcode;
  logic [5:0]  r_rd, r_rs, r_rt;
  logic        r_gen;

  logic        w_id_load_mem, w_id_load_skid, w_id_load, w_id_clr;
  logic        w_skid_load, w_skid_clr, w_target_load;
  logic [21:0] w_ld_word;
  logic [31:0] w_ld_pc;
  logic        w_unused;

  // Low instruction bits carry no decode information.
  assign w_unused = &{1'b0, i_imem_rdata[9:0]};

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state and datapath control; redirect outranks ack and stall.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_load_mem  = 1'b0;
    w_id_load_skid = 1'b0;
    w_id_clr       = 1'b0;
    w_skid_load    = 1'b0;
    w_skid_clr     = 1'b0;
    w_target_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (i_redirect) w_pc_nxt = i_redirect_pc;
      end
      S_FETCH: begin
        if (i_redirect) begin
          w_id_clr   = 1'b1;
          w_skid_clr = 1'b1;
          if (i_imem_ack) begin
            w_pc_nxt = i_redirect_pc;
          end else begin
            // Request still in flight: keep its address until it is acked.
            w_target_load = 1'b1;
            w_state_nxt   = S_DRAIN;
          end
        end else if (i_imem_ack) begin
          w_pc_nxt = r_pc + 32'd1;
          if (!i_stall || !r_id_valid) begin
            w_id_load_mem = 1'b1;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (!i_stall) begin
          w_id_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_redirect) w_target_load = 1'b1;
        if (i_imem_ack) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = i_redirect ? i_redirect_pc : r_target;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_id_clr    = 1'b1;
          w_skid_clr  = 1'b1;
          w_pc_nxt    = i_redirect_pc;
          w_state_nxt = S_FETCH;
        end else if (!i_stall) begin
          w_id_load_skid = r_skid_valid;
          w_skid_clr     = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_id_load = w_id_load_mem | w_id_load_skid;
  assign w_ld_word = w_id_load_skid ? r_skid_word : i_imem_rdata[31:10];
  assign w_ld_pc   = w_id_load_skid ? r_skid_pc   : r_pc;

  // PC, drain target, skid buffer and ID register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc         <= RESET_PC;
      r_target     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_word  <= '0;
      r_skid_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_opcode     <= '0;
      r_rd         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_gen        <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_target_load) r_target <= i_redirect_pc;
      if (w_skid_load) begin
        r_skid_valid <= 1'b1;
        r_skid_word  <= i_imem_rdata[31:10];
        r_skid_pc    <= r_pc;
      end else if (w_skid_clr) begin
        r_skid_valid <= 1'b0;
      end
      if (w_id_clr)       r_id_valid <= 1'b0;
      else if (w_id_load) r_id_valid <= 1'b1;
      if (w_id_load) begin
        r_id_pc  <= w_ld_pc;
        r_opcode <= w_ld_word[21:18];
        r_rd     <= w_ld_word[17:12];
        r_rs     <= w_ld_word[11:6];
        r_rt     <= w_ld_word[5:0];
        r_gen    <= (w_ld_word[21:18] == SVPC_OP);
      end
    end
  end

  assign o_imem_req  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign o_imem_addr = r_pc;
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_pc;
  assign o_opcode    = r_opcode;
  assign o_rd        = r_rd;
  assign o_rs        = r_rs;
  assign o_rt        = r_rt;
  assign o_const     = {r_rs, r_rt};
  assign o_Gen       = r_gen;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: vector table plus reset/redirect sequences.
module tb_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [3:0]  opcode;
  logic [5:0]  rd, rs, rt;
  logic [11:0] cnst;
  logic        gen;

  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_decode #(.RESET_PC(32'h0000_0000), .SVPC_OP(4'b1111)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_id_valid   (id_valid),
    .o_id_pc      (id_pc),
    .o_opcode     (opcode),
    .o_rd         (rd),
    .o_rs         (rs),
    .o_rt         (rt),
    .o_const      (cnst),
    .o_Gen        (gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_idpc;
    logic [3:0]  e_op;
    logic [5:0]  e_rd;
    logic [11:0] e_cnst;
    logic        e_gen;
  } vec_t;

  // W1: op=4 rd=1 rs=2 rt=3 -> const 083, Gen 0
  // W2: op=F rd=0 rs=3F rt=01 -> const FC1, Gen 1
  localparam logic [31:0] W1 = {4'b0100, 6'd1, 6'd2, 6'd3, 10'h155};
  localparam logic [31:0] W2 = {4'b1111, 6'd0, 6'h3F, 6'h01, 10'h2AA};

  function automatic vec_t mkv(
    input logic ack, input logic [31:0] rdata, input logic stl,
    input logic redir, input logic [31:0] rpc,
    input logic e_req, input logic [31:0] e_addr, input logic e_idv,
    input logic [31:0] e_idpc, input logic [3:0] e_op, input logic [5:0] e_rd,
    input logic [11:0] e_cnst, input logic e_gen);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.stall = stl; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_idv = e_idv; v.e_idpc = e_idpc;
    v.e_op = e_op; v.e_rd = e_rd; v.e_cnst = e_cnst; v.e_gen = e_gen;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_idv, input logic [31:0] e_idpc, input logic [3:0] e_op,
                         input logic [5:0] e_rd, input logic [11:0] e_cnst, input logic e_gen);
    chk({tag, " req"},    32'(imem_req),  32'(e_req));
    chk({tag, " addr"},   imem_addr,      e_addr);
    chk({tag, " valid"},  32'(id_valid),  32'(e_idv));
    chk({tag, " id_pc"},  id_pc,          e_idpc);
    chk({tag, " opcode"}, 32'(opcode),    32'(e_op));
    chk({tag, " rd"},     32'(rd),        32'(e_rd));
    chk({tag, " rs"},     32'(rs),        32'(e_cnst[11:6]));
    chk({tag, " rt"},     32'(rt),        32'(e_cnst[5:0]));
    chk({tag, " const"},  32'(cnst),      32'(e_cnst));
    chk({tag, " gen"},    32'(gen),       32'(e_gen));
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic redir, input logic [31:0] rpc);
    imem_ack = ack; imem_rdata = rdata; stall = stl; redirect = redir; redirect_pc = rpc;
  endtask

  vec_t vecs[29];

  initial begin
    vecs[0]  = mkv(1, W2, 0, 0, 0,            1, 32'h0,   0, 32'h0,   4'h0, 6'd0, 12'h000, 0);
    vecs[1]  = mkv(1, W1, 0, 0, 0,            1, 32'h1,   1, 32'h0,   4'h4, 6'd1, 12'h083, 0);
    vecs[2]  = mkv(1, W1, 0, 0, 0,            1, 32'h2,   1, 32'h1,   4'h4, 6'd1, 12'h083, 0);
    vecs[3]  = mkv(1, W2, 0, 0, 0,            1, 32'h3,   1, 32'h2,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[4]  = mkv(0, 0,  0, 0, 0,            1, 32'h3,   0, 32'h2,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[5]  = mkv(1, W1, 0, 0, 0,            1, 32'h4,   1, 32'h3,   4'h4, 6'd1, 12'h083, 0);
    vecs[6]  = mkv(1, W2, 0, 0, 0,            1, 32'h5,   1, 32'h4,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[7]  = mkv(1, W1, 1, 0, 0,            0, 32'h6,   1, 32'h4,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[8]  = mkv(0, 0,  1, 0, 0,            0, 32'h6,   1, 32'h4,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[9]  = mkv(0, 0,  1, 0, 0,            0, 32'h6,   1, 32'h4,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[10] = mkv(0, 0,  0, 0, 0,            1, 32'h6,   1, 32'h5,   4'h4, 6'd1, 12'h083, 0);
    vecs[11] = mkv(1, W2, 0, 0, 0,            1, 32'h7,   1, 32'h6,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[12] = mkv(0, 0,  1, 0, 0,            1, 32'h7,   1, 32'h6,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[13] = mkv(0, 0,  0, 0, 0,            1, 32'h7,   0, 32'h6,   4'hF, 6'd0, 12'hFC1, 1);
    vecs[14] = mkv(1, W1, 1, 0, 0,            1, 32'h8,   1, 32'h7,   4'h4, 6'd1, 12'h083, 0);
    vecs[15] = mkv(0, 0,  0, 1, 32'h40,       1, 32'h8,   0, 32'h7,   4'h4, 6'd1, 12'h083, 0);
    vecs[16] = mkv(0, 0,  0, 0, 0,            1, 32'h8,   0, 32'h7,   4'h4, 6'd1, 12'h083, 0);
    vecs[17] = mkv(1, W2, 0, 0, 0,            1, 32'h40,  0, 32'h7,   4'h4, 6'd1, 12'h083, 0);
    vecs[18] = mkv(1, W1, 0, 0, 0,            1, 32'h41,  1, 32'h40,  4'h4, 6'd1, 12'h083, 0);
    vecs[19] = mkv(1, W2, 1, 1, 32'h100,      1, 32'h100, 0, 32'h40,  4'h4, 6'd1, 12'h083, 0);
    vecs[20] = mkv(1, W1, 0, 0, 0,            1, 32'h101, 1, 32'h100, 4'h4, 6'd1, 12'h083, 0);
    vecs[21] = mkv(0, 0,  0, 1, 32'h200,      1, 32'h101, 0, 32'h100, 4'h4, 6'd1, 12'h083, 0);
    vecs[22] = mkv(0, 0,  0, 1, 32'h300,      1, 32'h101, 0, 32'h100, 4'h4, 6'd1, 12'h083, 0);
    vecs[23] = mkv(1, W2, 0, 0, 0,            1, 32'h300, 0, 32'h100, 4'h4, 6'd1, 12'h083, 0);
    vecs[24] = mkv(1, W2, 0, 0, 0,            1, 32'h301, 1, 32'h300, 4'hF, 6'd0, 12'hFC1, 1);
    vecs[25] = mkv(1, W1, 1, 0, 0,            0, 32'h302, 1, 32'h300, 4'hF, 6'd0, 12'hFC1, 1);
    vecs[26] = mkv(0, 0,  1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 32'h300, 4'hF, 6'd0, 12'hFC1, 1);
    vecs[27] = mkv(1, W1, 0, 0, 0,            1, 32'h0,   1, 32'hFFFF_FFFF, 4'h4, 6'd1, 12'h083, 0);
    vecs[28] = mkv(1, W2, 0, 0, 0,            1, 32'h1,   1, 32'h0,   4'hF, 6'd0, 12'hFC1, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 32'h0, 0, 32'h0, 4'h0, 6'd0, 12'h000, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_idv,
              vecs[i].e_idpc, vecs[i].e_op, vecs[i].e_rd, vecs[i].e_cnst, vecs[i].e_gen);
    end

    // Reset asserted mid-DRAIN: outputs clear at once, post-release ack ignored.
    drive(0, 0, 0, 1, 32'h50);
    @(posedge clk);
    #1;
    chk_all("drain", 1, 32'h1, 0, 32'h0, 4'hF, 6'd0, 12'hFC1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 32'h0, 0, 32'h0, 4'h0, 6'd0, 12'h000, 0);
    drive(1, W1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 32'h0, 0, 32'h0, 4'h0, 6'd0, 12'h000, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle_ack", 1, 32'h0, 0, 32'h0, 4'h0, 6'd0, 12'h000, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 1, 32'h1, 1, 32'h0, 4'h4, 6'd1, 12'h083, 0);

    // Redirect while in IDLE: first fetch goes to the redirect target.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    drive(1, W2, 0, 1, 32'h20);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle_redir", 1, 32'h20, 0, 32'h0, 4'h0, 6'd0, 12'h000, 0);
    drive(1, W1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("idle_redir_ld", 1, 32'h21, 1, 32'h20, 4'h4, 6'd1, 12'h083, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
